led_anim_sched: RTL and testbench

Sequencer for the 8-LED animation datapath. It owns the step-rate prescaler, the frame/step counters and the current animation mode, and it produces the registered LED pattern each step. Mode changes arrive from the board/control logic over a valid/ready handshake. They are applied only at frame boundaries, so a running animation is never cut mid-frame while enabled.

---
 rtl/led_anim_pkg.sv | 51 +++++
 rtl/led_anim_sched_prescaler.sv | 47 ++++
 rtl/led_anim_sched.sv | 135 +++++++++++++
 tb/tb_led_anim_sched.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/led_anim_pkg.sv
// led_anim_pkg: shared definitions for the LED animation sequencer.
//   mode_e        - animation mode codes as carried on mode_req / cur_mode
//   state_e       - sequencer state encoding
//   LEN_*         - frame length (steps per frame) for each mode
//   frame_last()  - index of the last step of a frame for a mode
//   pattern()     - 8-bit LED pattern for (mode, step)
package led_anim_pkg;

  typedef enum logic [1:0] {
    MODE_BAR   = 2'd0,
    MODE_CHASE = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_OFF   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  localparam int unsigned LEN_BAR   = 16;
  localparam int unsigned LEN_CHASE = 8;
  localparam int unsigned LEN_BLINK = 2;
  localparam int unsigned LEN_OFF   = 1;

  function automatic logic [3:0] frame_last(input mode_e m);
    case (m)
      MODE_BAR:   frame_last = 4'(LEN_BAR - 1);
      MODE_CHASE: frame_last = 4'(LEN_CHASE - 1);
      MODE_BLINK: frame_last = 4'(LEN_BLINK - 1);
      default:    frame_last = 4'(LEN_OFF - 1);
    endcase
  endfunction

  function automatic logic [7:0] pattern(input mode_e m, input logic [3:0] k);
    pattern = '0;
    case (m)
      MODE_BAR: begin
        // Fill up over steps 0..7, drain over 8..14, dark on 15.
        if (k <= 4'd7)       pattern = 8'hFF >> (4'd7 - k);
        else if (k <= 4'd14) pattern = 8'hFF >> (k - 4'd7);
        else                 pattern = '0;
      end
      MODE_CHASE: pattern = 8'h01 << k[2:0];
      MODE_BLINK: pattern = k[0] ? 8'h00 : 8'hFF;
      default:    pattern = '0;
    endcase
  endfunction

endpackage

// File: rtl/led_anim_sched_prescaler.sv
// anim_prescaler: step-rate divider for the LED animation sequencer.
//   clk, rst  - clock, synchronous active-low reset
//   run       - count enable; when low the counter is held at zero
//   div_cfg   - cycles per step, 0 selects DEFAULT_DIV
//   step_tick - high on the last cycle of each step
module anim_prescaler #(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 462
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] div_cfg,
  output logic             step_tick
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] d_q, d_d;
  logic [DIV_W-1:0] d_cfg, d_eff;

  always_comb begin
    d_cfg     = (div_cfg == '0) ? DIV_W'(DEFAULT_DIV) : div_cfg;
    // On the first cycle of a step the divider comes straight from div_cfg,
    // so D=1 can tick immediately; later cycles use the latched copy.
    d_eff     = (div_cnt_q == '0) ? d_cfg : d_q;
    step_tick = run && (div_cnt_q == d_eff - DIV_W'(1));
    d_d       = d_q;
    div_cnt_d = div_cnt_q;
    if (!run) begin
      div_cnt_d = '0;
    end else begin
      if (div_cnt_q == '0) d_d = d_cfg;
      div_cnt_d = step_tick ? '0 : div_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt_q <= '0;
      d_q       <= DIV_W'(DEFAULT_DIV);
    end else begin
      div_cnt_q <= div_cnt_d;
      d_q       <= d_d;
    end
  end

endmodule

// File: rtl/led_anim_sched.sv
// led_anim_sched: sequencer for the 8-LED animation datapath.
//   clk, rst    - clock, synchronous active-low reset
//   en          - animation enable (0 blanks LEDs, holds counters)
//   div_cfg     - clock cycles per step (0 = DEFAULT_DIV)
//   mode_req/mode_valid/mode_ready - mode change handshake
//   led         - registered LED pattern
//   cur_mode    - mode currently displayed
//   step        - step index within the frame
//   frame_done  - one-cycle pulse when a frame wraps
module led_anim_sched
  import led_anim_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DIV_W        = 16,
  parameter int unsigned DEFAULT_DIV  = 462,
  parameter int unsigned DEFAULT_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_cfg,
  input  logic [1:0]       mode_req,
  input  logic             mode_valid,
  output logic             mode_ready,
  output logic [WIDTH-1:0] led,
  output logic [1:0]       cur_mode,
  output logic [3:0]       step,
  output logic             frame_done
);

  state_e           state_q, state_d;
  mode_e            cur_mode_q, cur_mode_d;
  mode_e            pend_q, pend_d;
  logic [3:0]       step_q, step_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             frame_done_q, frame_done_d;
  logic             mode_ready_q, mode_ready_d;
  logic             step_tick, run, accept, wrap;
  mode_e            req_mode;

  assign run = en && (state_q != ST_IDLE);

  anim_prescaler #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .div_cfg   (div_cfg),
    .step_tick (step_tick)
  );

  always_comb begin
    accept       = mode_valid && mode_ready_q;
    req_mode     = mode_e'(mode_req);
    wrap         = step_tick && (step_q == frame_last(cur_mode_q));
    state_d      = state_q;
    cur_mode_d   = cur_mode_q;
    pend_d       = pend_q;
    step_d       = step_q;
    led_d        = led_q;
    frame_done_d = 1'b0;
    mode_ready_d = mode_ready_q;
    case (state_q)
      ST_IDLE: begin
        led_d        = '0;
        step_d       = '0;
        mode_ready_d = 1'b1;
        if (accept) cur_mode_d = req_mode;
        if (en) begin
          state_d = ST_RUN;
          led_d   = WIDTH'(pattern(cur_mode_d, 4'd0));
        end
      end
      ST_RUN, ST_PEND: begin
        if (!en) begin
          state_d      = ST_IDLE;
          led_d        = '0;
          step_d       = '0;
          mode_ready_d = 1'b1;
          if (state_q == ST_PEND) cur_mode_d = pend_q;
          else if (accept)        cur_mode_d = req_mode;
        end else if (wrap) begin
          // A request landing on the wrap tick bypasses PEND entirely.
          if (state_q == ST_PEND) cur_mode_d = pend_q;
          else if (accept)        cur_mode_d = req_mode;
          state_d      = ST_RUN;
          step_d       = '0;
          frame_done_d = 1'b1;
          mode_ready_d = 1'b1;
          led_d        = WIDTH'(pattern(cur_mode_d, 4'd0));
        end else begin
          if (step_tick) begin
            step_d = step_q + 4'd1;
            led_d  = WIDTH'(pattern(cur_mode_q, step_q + 4'd1));
          end
          if (state_q == ST_RUN && accept) begin
            pend_d       = req_mode;
            state_d      = ST_PEND;
            mode_ready_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cur_mode_q   <= mode_e'(2'(DEFAULT_MODE));
      pend_q       <= MODE_BAR;
      step_q       <= '0;
      led_q        <= '0;
      frame_done_q <= 1'b0;
      mode_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_mode_q   <= cur_mode_d;
      pend_q       <= pend_d;
      step_q       <= step_d;
      led_q        <= led_d;
      frame_done_q <= frame_done_d;
      mode_ready_q <= mode_ready_d;
    end
  end

  assign led        = led_q;
  assign cur_mode   = cur_mode_q;
  assign step       = step_q;
  assign frame_done = frame_done_q;
  assign mode_ready = mode_ready_q;

endmodule

// File: tb/tb_led_anim_sched.sv
module tb_led_anim_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [15:0] div_cfg = '0;
  logic [1:0]  mode_req = '0;
  logic        mode_valid = 1'b0;
  logic        mode_ready;
  logic [7:0]  led;
  logic [1:0]  cur_mode;
  logic [3:0]  step;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  led_anim_sched #(
    .WIDTH        (8),
    .DIV_W        (16),
    .DEFAULT_DIV  (462),
    .DEFAULT_MODE (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .div_cfg    (div_cfg),
    .mode_req   (mode_req),
    .mode_valid (mode_valid),
    .mode_ready (mode_ready),
    .led        (led),
    .cur_mode   (cur_mode),
    .step       (step),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en;
    logic [1:0] req;
    logic       valid;
    logic [7:0] led;
    logic [3:0] step;
    logic [1:0] mode;
    logic       fd, rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic v(input logic r, input logic e, input logic [1:0] q, input logic vl,
                   input logic [7:0] l, input logic [3:0] s, input logic [1:0] m,
                   input logic f, input logic rd);
    vec_t x;
    x.rst = r; x.en = e; x.req = q; x.valid = vl;
    x.led = l; x.step = s; x.mode = m; x.fd = f; x.rdy = rd;
    tbl.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; mode_valid = 1'b0; mode_req = '0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  // Independent statement of the BAR sequence: fill 0x01..0xFF, drain 0x7F..0x01, dark.
  function automatic int bar_pat(input int k);
    if (k <= 7)       return (1 << (k + 1)) - 1;
    else if (k <= 14) return (1 << (15 - k)) - 1;
    else              return 0;
  endfunction

  initial begin
    int n;

    // BAR frame at 2 cycles per step.
    do_reset();
    chk("rst_release_ready", int'(mode_ready), 1);
    en = 1'b1; div_cfg = 16'd2;
    tick();
    for (int c = 0; c < 32; c++) begin
      if (c > 0) tick();
      chk($sformatf("bar2_led_c%0d", c), int'(led), bar_pat(c / 2));
      chk($sformatf("bar2_fd_c%0d", c), int'(frame_done), 0);
    end
    tick();
    chk("bar2_wrap_fd", int'(frame_done), 1);
    chk("bar2_wrap_led", int'(led), 1);
    chk("bar2_wrap_mode", int'(cur_mode), 0);
    tick();
    chk("bar2_fd_pulse_end", int'(frame_done), 0);

    // Default divider, then a mid-step div_cfg change.
    do_reset();
    en = 1'b1; div_cfg = 16'd0;
    tick();
    n = 1;
    for (int g = 0; g < 2000; g++) begin
      tick();
      if (step != 4'd0) break;
      n++;
    end
    chk("div0_step0_len", n, 462);
    chk("div0_step_after", int'(step), 1);
    n = 1;
    for (int g = 0; g < 2000; g++) begin
      if (n == 100) div_cfg = 16'd3;
      tick();
      if (step != 4'd1) break;
      n++;
    end
    chk("div_midchange_step1_len", n, 462);
    n = 1;
    for (int g = 0; g < 2000; g++) begin
      tick();
      if (step != 4'd2) break;
      n++;
    end
    chk("div3_step2_len", n, 3);

    // Cycle-by-cycle vectors at 1 cycle per step.
    div_cfg = 16'd1;
    //rst en req vld  led   stp mode fd rdy
    v(0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    v(1, 0, 0, 0, 8'h00, 0, 0, 0, 1);
    v(1, 0, 1, 1, 8'h00, 0, 1, 0, 1);
    v(1, 0, 0, 1, 8'h00, 0, 0, 0, 1);
    v(1, 1, 0, 0, 8'h01, 0, 0, 0, 1);
    v(1, 1, 0, 0, 8'h03, 1, 0, 0, 1);
    v(1, 1, 0, 0, 8'h07, 2, 0, 0, 1);
    v(1, 1, 0, 0, 8'h0F, 3, 0, 0, 1);
    v(1, 1, 0, 0, 8'h1F, 4, 0, 0, 1);
    v(1, 1, 0, 0, 8'h3F, 5, 0, 0, 1);
    v(1, 1, 1, 1, 8'h7F, 6, 0, 0, 0);   // CHASE accepted -> PEND
    v(1, 1, 0, 0, 8'hFF, 7, 0, 0, 0);
    v(1, 1, 0, 0, 8'h7F, 8, 0, 0, 0);
    v(1, 1, 0, 0, 8'h3F, 9, 0, 0, 0);
    v(1, 1, 0, 0, 8'h1F, 10, 0, 0, 0);
    v(1, 1, 0, 0, 8'h0F, 11, 0, 0, 0);
    v(1, 1, 0, 0, 8'h07, 12, 0, 0, 0);
    v(1, 1, 0, 0, 8'h03, 13, 0, 0, 0);
    v(1, 1, 0, 0, 8'h01, 14, 0, 0, 0);
    v(1, 1, 0, 0, 8'h00, 15, 0, 0, 0);
    v(1, 1, 0, 0, 8'h01, 0, 1, 1, 1);   // wrap into CHASE
    v(1, 1, 0, 0, 8'h02, 1, 1, 0, 1);
    v(1, 1, 0, 0, 8'h04, 2, 1, 0, 1);
    v(1, 1, 0, 0, 8'h08, 3, 1, 0, 1);
    v(1, 1, 0, 0, 8'h10, 4, 1, 0, 1);
    v(1, 1, 0, 0, 8'h20, 5, 1, 0, 1);
    v(1, 1, 0, 0, 8'h40, 6, 1, 0, 1);
    v(1, 1, 0, 0, 8'h80, 7, 1, 0, 1);
    v(1, 1, 2, 1, 8'hFF, 0, 2, 1, 1);   // BLINK on the wrap tick
    v(1, 1, 0, 0, 8'h00, 1, 2, 0, 1);
    v(1, 1, 0, 0, 8'hFF, 0, 2, 1, 1);
    v(1, 1, 0, 0, 8'h00, 1, 2, 0, 1);
    v(1, 1, 3, 1, 8'h00, 0, 3, 1, 1);   // OFF: one-step frames
    v(1, 1, 0, 0, 8'h00, 0, 3, 1, 1);
    v(1, 1, 0, 1, 8'h01, 0, 0, 1, 1);   // back to BAR on wrap
    v(1, 1, 0, 0, 8'h03, 1, 0, 0, 1);
    v(1, 1, 0, 0, 8'h07, 2, 0, 0, 1);
    v(1, 1, 0, 0, 8'h0F, 3, 0, 0, 1);
    v(1, 1, 0, 0, 8'h1F, 4, 0, 0, 1);
    v(1, 1, 0, 0, 8'h3F, 5, 0, 0, 1);
    v(1, 1, 0, 0, 8'h7F, 6, 0, 0, 1);
    v(1, 1, 0, 0, 8'hFF, 7, 0, 0, 1);
    v(1, 1, 0, 0, 8'h7F, 8, 0, 0, 1);
    v(1, 1, 1, 1, 8'h3F, 9, 0, 0, 0);   // CHASE pending at step 9
    v(1, 0, 0, 0, 8'h00, 0, 1, 0, 1);   // en drop applies pending
    v(1, 1, 0, 0, 8'h01, 0, 1, 0, 1);
    v(1, 1, 0, 0, 8'h02, 1, 1, 0, 1);
    v(1, 1, 0, 0, 8'h04, 2, 1, 0, 1);
    v(1, 1, 0, 0, 8'h08, 3, 1, 0, 1);
    v(1, 1, 0, 0, 8'h10, 4, 1, 0, 1);
    v(1, 1, 2, 1, 8'h20, 5, 1, 0, 0);   // BLINK pending
    v(1, 1, 0, 0, 8'h40, 6, 1, 0, 0);
    v(1, 1, 0, 0, 8'h80, 7, 1, 0, 0);
    v(0, 1, 0, 0, 8'h00, 0, 0, 0, 0);   // reset during PEND
    v(1, 1, 0, 0, 8'h01, 0, 0, 0, 1);
    v(1, 1, 0, 0, 8'h03, 1, 0, 0, 1);
    v(1, 1, 0, 0, 8'h07, 2, 0, 0, 1);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; en = tbl[i].en;
      mode_req = tbl[i].req; mode_valid = tbl[i].valid;
      tick();
      chk($sformatf("v%0d_led", i),  int'(led),        int'(tbl[i].led));
      chk($sformatf("v%0d_step", i), int'(step),       int'(tbl[i].step));
      chk($sformatf("v%0d_mode", i), int'(cur_mode),   int'(tbl[i].mode));
      chk($sformatf("v%0d_fd", i),   int'(frame_done), int'(tbl[i].fd));
      chk($sformatf("v%0d_rdy", i),  int'(mode_ready), int'(tbl[i].rdy));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
